// File: rtl/turbo_iter_ctrl.sv
// Turbo decoder iteration controller: buffers one block, drives a shared SISO in natural and interleaved passes.
// Optional early stop on stable hard decisions is enabled by defining TURBO_EARLY_STOP_EN.
module turbo_iter_ctrl #(
   parameter int K        = 5,
   parameter int IN_W     = 4,
   parameter int EXT_W    = 10,
   parameter int P        = 2,
   parameter int MAX_ITER = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start_i,
   input  logic             in_valid_i,
   input  logic [IN_W-1:0]  sys_i,
   input  logic [IN_W-1:0]  par1_i,
   input  logic [IN_W-1:0]  par2_i,
   output logic             siso_valid_o,
   output logic             siso_first_o,
   output logic             siso_sel_o,
   output logic [EXT_W-1:0] siso_sys_o,
   output logic [EXT_W-1:0] siso_par_o,
   output logic [EXT_W-1:0] siso_apr_o,
   input  logic             siso_valid_i,
   input  logic [EXT_W-1:0] siso_llr_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [K-1:0]     data_o,
   output logic [5:0]       iter_o
);

   localparam int AW = (K > 1) ? $clog2(K) : 1;
   localparam int IW = AW + 1;
   localparam logic [IW-1:0] K_LAST = IW'(K - 1);
   localparam logic [IW-1:0] K_VAL  = IW'(K);
   localparam logic [IW-1:0] P_STEP = IW'(P % K);

   typedef enum logic [2:0] {IDLE, LOAD, FEED1, WAIT1, FEED2, WAIT2, CHECK, FIN} state_t;

   state_t state_q, state_d;
   logic [IW-1:0] cnt_q, cnt_d, perm_q, perm_d, perm_step;
   logic [5:0] iter_q, iter_d;
   logic [K-1:0][IN_W-1:0] sys_q, sys_d, par1_q, par1_d, par2_q, par2_d;
   logic [K-1:0][EXT_W-1:0] ext_q, ext_d;
   logic [K-1:0] hd_q, hd_d;
`ifdef TURBO_EARLY_STOP_EN
   logic [K-1:0] hd_prev_q, hd_prev_d;
`endif
   logic [AW-1:0] m_idx, feed_idx;
   logic [EXT_W-1:0] s_ext, ext_new;
   logic stop;

   logic siso_valid_q, siso_valid_d, siso_first_q, siso_first_d, siso_sel_q, siso_sel_d;
   logic [EXT_W-1:0] siso_sys_q, siso_sys_d, siso_par_q, siso_par_d, siso_apr_q, siso_apr_d;
   logic busy_q, busy_d, done_q, done_d;
   logic [K-1:0] data_q, data_d;
   logic [5:0] iter_out_q, iter_out_d;

   function automatic logic [EXT_W-1:0] sext(input logic [IN_W-1:0] v);
      sext = {{(EXT_W-IN_W){v[IN_W-1]}}, v};
   endfunction

   // One extra bit catches the overflow; a disagreement of the top two bits means clamp.
   function automatic logic [EXT_W-1:0] sat_sub(input logic [EXT_W-1:0] a, input logic [EXT_W-1:0] b);
      logic [EXT_W:0] d;
      d = {a[EXT_W-1], a} - {b[EXT_W-1], b};
      if (d[EXT_W] != d[EXT_W-1])
         sat_sub = d[EXT_W] ? {1'b1, {(EXT_W-1){1'b0}}} : {1'b0, {(EXT_W-1){1'b1}}};
      else
         sat_sub = d[EXT_W-1:0];
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      perm_d  = perm_q;
      iter_d  = iter_q;
      sys_d   = sys_q;
      par1_d  = par1_q;
      par2_d  = par2_q;
      ext_d   = ext_q;
      hd_d    = hd_q;
`ifdef TURBO_EARLY_STOP_EN
      hd_prev_d = hd_prev_q;
`endif
      stop = 1'b0;
      perm_step = perm_q + P_STEP;
      if (perm_step >= K_VAL) perm_step = perm_step - K_VAL;
      // In the interleaved pass the n-th posterior belongs to natural index pi(n).
      m_idx   = (state_q == WAIT2) ? perm_q[AW-1:0] : cnt_q[AW-1:0];
      s_ext   = sext(sys_q[m_idx]);
      ext_new = sat_sub(sat_sub(sat_sub(siso_llr_i, ext_q[m_idx]), s_ext), s_ext);
      case (state_q)
         IDLE: if (start_i) begin
            ext_d   = '0;
            cnt_d   = '0;
            iter_d  = '0;
            state_d = LOAD;
         end
         LOAD: if (in_valid_i) begin
            sys_d[cnt_q[AW-1:0]]  = sys_i;
            par1_d[cnt_q[AW-1:0]] = par1_i;
            par2_d[cnt_q[AW-1:0]] = par2_i;
            cnt_d = cnt_q + IW'(1);
            if (cnt_q == K_LAST) begin
               cnt_d   = '0;
               perm_d  = '0;
               state_d = FEED1;
            end
         end
         FEED1, FEED2: begin
            cnt_d  = cnt_q + IW'(1);
            perm_d = perm_step;
            if (cnt_q == K_LAST) begin
               cnt_d   = '0;
               perm_d  = '0;
               state_d = (state_q == FEED1) ? WAIT1 : WAIT2;
            end
         end
         WAIT1, WAIT2: if (siso_valid_i) begin
            ext_d[m_idx] = ext_new;
            if (state_q == WAIT2) hd_d[m_idx] = siso_llr_i[EXT_W-1];
            cnt_d  = cnt_q + IW'(1);
            perm_d = perm_step;
            if (cnt_q == K_LAST) begin
               cnt_d   = '0;
               perm_d  = '0;
               state_d = (state_q == WAIT1) ? FEED2 : CHECK;
            end
         end
         CHECK: begin
            iter_d = iter_q + 6'd1;
            stop   = (iter_d == 6'(MAX_ITER));
`ifdef TURBO_EARLY_STOP_EN
            if (iter_d >= 6'd2 && hd_q == hd_prev_q) stop = 1'b1;
            hd_prev_d = hd_q;
`endif
            cnt_d   = '0;
            perm_d  = '0;
            state_d = stop ? FIN : FEED1;
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Everything visible is registered; done/data/iter are loaded on entry to FIN so they appear during FIN.
   always_comb begin
      siso_valid_d = (state_q == FEED1) || (state_q == FEED2);
      siso_first_d = siso_valid_d && (cnt_q == '0);
      siso_sel_d   = (state_q == FEED2);
      feed_idx     = (state_q == FEED2) ? perm_q[AW-1:0] : cnt_q[AW-1:0];
      siso_sys_d   = siso_valid_d ? sext(sys_q[feed_idx]) : '0;
      siso_apr_d   = siso_valid_d ? ext_q[feed_idx] : '0;
      siso_par_d   = '0;
      if (state_q == FEED1) siso_par_d = sext(par1_q[cnt_q[AW-1:0]]);
      if (state_q == FEED2) siso_par_d = sext(par2_q[cnt_q[AW-1:0]]);
      busy_d     = (state_d != IDLE);
      done_d     = (state_d == FIN);
      data_d     = done_d ? hd_q : data_q;
      iter_out_d = done_d ? iter_d : iter_out_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;  perm_q <= '0;  iter_q <= '0;
         sys_q <= '0;  par1_q <= '0;  par2_q <= '0;
         ext_q <= '0;  hd_q <= '0;
         siso_valid_q <= 1'b0;  siso_first_q <= 1'b0;  siso_sel_q <= 1'b0;
         siso_sys_q <= '0;  siso_par_q <= '0;  siso_apr_q <= '0;
         busy_q <= 1'b0;  done_q <= 1'b0;  data_q <= '0;  iter_out_q <= '0;
      end else begin
         cnt_q <= cnt_d;  perm_q <= perm_d;  iter_q <= iter_d;
         sys_q <= sys_d;  par1_q <= par1_d;  par2_q <= par2_d;
         ext_q <= ext_d;  hd_q <= hd_d;
         siso_valid_q <= siso_valid_d;  siso_first_q <= siso_first_d;  siso_sel_q <= siso_sel_d;
         siso_sys_q <= siso_sys_d;  siso_par_q <= siso_par_d;  siso_apr_q <= siso_apr_d;
         busy_q <= busy_d;  done_q <= done_d;  data_q <= data_d;  iter_out_q <= iter_out_d;
      end
   end

`ifdef TURBO_EARLY_STOP_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) hd_prev_q <= '0;
      else       hd_prev_q <= hd_prev_d;
   end
`endif

   assign siso_valid_o = siso_valid_q;
   assign siso_first_o = siso_first_q;
   assign siso_sel_o   = siso_sel_q;
   assign siso_sys_o   = siso_sys_q;
   assign siso_par_o   = siso_par_q;
   assign siso_apr_o   = siso_apr_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign data_o       = data_q;
   assign iter_o       = iter_out_q;

endmodule

// File: tb/tb_turbo_iter_ctrl.sv
// Scoreboard bench for turbo_iter_ctrl: a plain-arithmetic model predicts every SISO sample and result,
// a monitor process compares them as the DUT presents them.
module tb_turbo_iter_ctrl;

   localparam int K = 5, IN_W = 4, EXT_W = 10, P = 2, MAX_ITER = 4;
   localparam int SMAX = (1 << (EXT_W - 1)) - 1;
   localparam int SMIN = -(1 << (EXT_W - 1));
`ifdef TURBO_EARLY_STOP_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic clock = 1'b0, reset = 1'b1;
   logic start_i = 1'b0, in_valid_i = 1'b0;
   logic [IN_W-1:0] sys_i = '0, par1_i = '0, par2_i = '0;
   logic siso_valid_o, siso_first_o, siso_sel_o;
   logic [EXT_W-1:0] siso_sys_o, siso_par_o, siso_apr_o;
   logic siso_valid_i = 1'b0;
   logic [EXT_W-1:0] siso_llr_i = '0;
   logic busy_o, done_o;
   logic [K-1:0] data_o;
   logic [5:0] iter_o;

   turbo_iter_ctrl #(.K(K), .IN_W(IN_W), .EXT_W(EXT_W), .P(P), .MAX_ITER(MAX_ITER)) dut (
      .clock(clock), .reset(reset), .start_i(start_i), .in_valid_i(in_valid_i),
      .sys_i(sys_i), .par1_i(par1_i), .par2_i(par2_i),
      .siso_valid_o(siso_valid_o), .siso_first_o(siso_first_o), .siso_sel_o(siso_sel_o),
      .siso_sys_o(siso_sys_o), .siso_par_o(siso_par_o), .siso_apr_o(siso_apr_o),
      .siso_valid_i(siso_valid_i), .siso_llr_i(siso_llr_i),
      .busy_o(busy_o), .done_o(done_o), .data_o(data_o), .iter_o(iter_o));

   always #5 clock = ~clock;

   typedef struct { int sel; int first; int sys; int par; int apr; } feed_t;
   typedef struct { int data; int iter; } res_t;
   feed_t exp_feed_q[$];
   res_t  exp_res_q[$];
   int sys_a[K], par1_a[K], par2_a[K];
   int post_tab[$];
   int checks = 0, errors = 0;
   int last_data = 0, last_iter = 0;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic int sat(input int v);
      if (v > SMAX) return SMAX;
      if (v < SMIN) return SMIN;
      return v;
   endfunction

   function automatic int rand_llr();
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) return SMAX;
      if (r == 1) return SMIN;
      return int'($urandom_range(0, 2 * SMAX + 1)) + SMIN;
   endfunction

   // Reference: walks the iterations directly, with pi(i) = (P*i) mod K.
   task automatic run_model();
      int ext[K]; int hd[K]; int hd_prev[K];
      int it, base, m, j, same, L, bits;
      bit stop;
      feed_t f; res_t r;
      for (int k = 0; k < K; k++) begin ext[k] = 0; hd[k] = 0; hd_prev[k] = 0; end
      it = 0; base = 0; stop = 0;
      while (!stop) begin
         for (int i = 0; i < K; i++) begin
            f.sel = 0; f.first = (i == 0); f.sys = sys_a[i]; f.par = par1_a[i]; f.apr = ext[i];
            exp_feed_q.push_back(f);
         end
         for (int n = 0; n < K; n++) begin
            m = n; L = post_tab[base + n];
            ext[m] = sat(sat(sat(L - ext[m]) - sys_a[m]) - sys_a[m]);
         end
         base += K;
         for (int i = 0; i < K; i++) begin
            j = (P * i) % K;
            f.sel = 1; f.first = (i == 0); f.sys = sys_a[j]; f.par = par2_a[i]; f.apr = ext[j];
            exp_feed_q.push_back(f);
         end
         for (int n = 0; n < K; n++) begin
            m = (P * n) % K; L = post_tab[base + n];
            ext[m] = sat(sat(sat(L - ext[m]) - sys_a[m]) - sys_a[m]);
            hd[m] = (L < 0) ? 1 : 0;
         end
         base += K;
         it++;
         same = 1;
         for (int k = 0; k < K; k++) if (hd[k] != hd_prev[k]) same = 0;
         stop = (it == MAX_ITER) || (EARLY && it >= 2 && same == 1);
         hd_prev = hd;
      end
      bits = 0;
      for (int k = 0; k < K; k++) bits |= hd[k] << k;
      r.data = bits; r.iter = it;
      exp_res_q.push_back(r);
      last_data = bits; last_iter = it;
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a SISO sample or a result.
   initial begin
      feed_t e; res_t r;
      forever begin
         @(negedge clock);
         if (siso_valid_o) begin
            if (exp_feed_q.size() == 0) checkOutput("feed_unexpected", int'(siso_valid_o), 0);
            else begin
               e = exp_feed_q.pop_front();
               checkOutput("siso_sel", int'(siso_sel_o), e.sel);
               checkOutput("siso_first", int'(siso_first_o), e.first);
               checkOutput("siso_sys", int'($signed(siso_sys_o)), e.sys);
               checkOutput("siso_par", int'($signed(siso_par_o)), e.par);
               checkOutput("siso_apr", int'($signed(siso_apr_o)), e.apr);
            end
         end
         if (done_o) begin
            if (exp_res_q.size() == 0) checkOutput("done_unexpected", int'(done_o), 0);
            else begin
               r = exp_res_q.pop_front();
               checkOutput("data_o", int'(data_o), r.data);
               checkOutput("iter_o", int'(iter_o), r.iter);
            end
         end
      end
   end

   task automatic do_reset();
      siso_valid_i = 1'b0; in_valid_i = 1'b0; start_i = 1'b0;
      reset = 1'b1;
      exp_feed_q.delete(); exp_res_q.delete();
      last_data = 0; last_iter = 0;
      @(negedge clock);
      checkOutput("rst_busy", int'(busy_o), 0);
      checkOutput("rst_done", int'(done_o), 0);
      checkOutput("rst_siso_valid", int'(siso_valid_o), 0);
      checkOutput("rst_data", int'(data_o), 0);
      checkOutput("rst_iter", int'(iter_o), 0);
      reset = 1'b0;
      repeat (10) @(negedge clock);
      checkOutput("idle_busy_after_rst", int'(busy_o), 0);
   endtask

   task automatic wait_feed(input bit spur, output bit got_done, output bit tout);
      int cnt;
      cnt = 0; got_done = 0; tout = 1;
      for (int c = 0; c < 300; c++) begin
         @(negedge clock);
         if (done_o) begin got_done = 1; tout = 0; siso_valid_i = 1'b0; return; end
         if (siso_valid_o) cnt++;
         if (spur && cnt == 1) begin
            siso_valid_i = 1'b1; siso_llr_i = EXT_W'(rand_llr());
         end else siso_valid_i = 1'b0;
         if (cnt == K) begin tout = 0; siso_valid_i = 1'b0; return; end
      end
   endtask

   // kind: 0 random, 1 ramp sys (interleave order), 2 saturation corners, 3 echo SISO
   task automatic applyStimulus(input int kind, input int reset_at, input bit spur);
      bit got_done, tout, aborted;
      int pass;
      repeat (3) @(negedge clock);
      checkOutput("data_hold", int'(data_o), last_data);
      checkOutput("iter_hold", int'(iter_o), last_iter);
      for (int i = 0; i < K; i++) begin
         sys_a[i]  = int'($urandom_range(0, 15)) - 8;
         par1_a[i] = int'($urandom_range(0, 15)) - 8;
         par2_a[i] = int'($urandom_range(0, 15)) - 8;
      end
      if (kind == 1) for (int i = 0; i < K; i++) sys_a[i] = i;
      if (kind == 2) begin sys_a[0] = -8; sys_a[1] = 8 - 1; sys_a[2] = 3; sys_a[3] = -3; sys_a[4] = 0; end
      if (kind == 3) for (int i = 0; i < K; i++) sys_a[i] = (i % 2 == 0) ? 3 : -3;
      post_tab.delete();
      for (int it = 0; it < MAX_ITER; it++) begin
         for (int n = 0; n < K; n++) post_tab.push_back((kind == 3) ? 4 * sys_a[n] : rand_llr());
         for (int n = 0; n < K; n++) post_tab.push_back((kind == 3) ? 4 * sys_a[(P * n) % K] : rand_llr());
      end
      if (kind == 2) begin
         post_tab[0] = -116;
         post_tab[1] = 114;
         post_tab[K] = SMAX;
         post_tab[K + 3] = SMIN;
      end
      run_model();
      start_i = 1'b1;
      @(negedge clock);
      start_i = 1'b0;
      for (int i = 0; i < K; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            in_valid_i = 1'b0; sys_i = IN_W'($urandom); start_i = spur;
            @(negedge clock);
         end
         in_valid_i = 1'b1; start_i = spur;
         sys_i = IN_W'(sys_a[i]); par1_i = IN_W'(par1_a[i]); par2_i = IN_W'(par2_a[i]);
         @(negedge clock);
      end
      in_valid_i = 1'b0; start_i = 1'b0;
      pass = 0; aborted = 0;
      while (1) begin
         wait_feed(spur && pass == 0, got_done, tout);
         checkOutput("wait_timeout", int'(tout), 0);
         if (tout) begin do_reset(); return; end
         if (got_done) break;
         for (int n = 0; n < K; n++) begin
            if (reset_at > 0 && pass == 0 && n == reset_at) begin aborted = 1; break; end
            if ($urandom_range(0, 3) == 0) begin
               siso_valid_i = 1'b0; siso_llr_i = EXT_W'($urandom);
               @(negedge clock);
            end
            siso_valid_i = 1'b1; siso_llr_i = EXT_W'(post_tab[pass * K + n]);
            @(negedge clock);
         end
         siso_valid_i = 1'b0;
         if (aborted) begin do_reset(); return; end
         pass++;
         if (pass > 2 * MAX_ITER) begin
            checkOutput("pass_overrun", pass, 2 * MAX_ITER);
            do_reset();
            return;
         end
      end
      checkOutput("pass_count", pass, 2 * last_iter);
      @(negedge clock);
      checkOutput("idle_after_done", int'(busy_o), 0);
   endtask

   initial begin
      repeat (3) @(negedge clock);
      checkOutput("reset_busy", int'(busy_o), 0);
      checkOutput("reset_done", int'(done_o), 0);
      checkOutput("reset_data", int'(data_o), 0);
      checkOutput("reset_iter", int'(iter_o), 0);
      checkOutput("reset_siso_valid", int'(siso_valid_o), 0);
      checkOutput("reset_siso_sys", int'(siso_sys_o), 0);
      checkOutput("reset_siso_apr", int'(siso_apr_o), 0);
      reset = 1'b0;
      @(negedge clock);
      applyStimulus(1, 0, 1'b0);
      applyStimulus(2, 0, 1'b1);
      applyStimulus(3, 0, 1'b0);
      checkOutput("echo_data", int'(data_o), 10);
      checkOutput("echo_iter", int'(iter_o), EARLY ? 2 : MAX_ITER);
      applyStimulus(0, 2, 1'b0);
      checkOutput("after_abort_done", int'(done_o), 0);
      for (int b = 0; b < 5; b++) applyStimulus(0, 0, b[0]);
      applyStimulus(3, 0, 1'b1);
      checkOutput("feed_leftover", exp_feed_q.size(), 0);
      checkOutput("result_leftover", exp_res_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
